// File: rtl/noc_link_buffer.sv
`default_nettype none
// ============================================================================
// Module      : noc_link_buffer
// Description : Elastic link stage between two adjacent routers. A DEPTH-entry
//               FIFO breaks the inter-router timing path, a per-VC framing
//               checker watches head/body/tail ordering, and saturating
//               counters track delivered flits and packets. Flits always pass
//               through unchanged.
// Ports       : clk, arst (async, active-low)
//               in_fdata/in_vc_id/in_valid/in_ready     upstream side
//               out_fdata/out_vc_id/out_valid/out_ready downstream side
//               clr_stats                               clears counters/errors
//               flit_cnt, pkt_cnt, err, err_vc          link statistics
// Revision    : 1.0 - initial release
// ============================================================================
module noc_link_buffer #(
    parameter int FLIT_WIDTH = 34,
    parameter int N_VIRT_CHN = 3,
    parameter int VC_WIDTH   = 2,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [FLIT_WIDTH-1:0] in_fdata,
    input  logic [VC_WIDTH-1:0]   in_vc_id,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_fdata,
    output logic [VC_WIDTH-1:0]   out_vc_id,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  clr_stats,
    output logic [CNT_WIDTH-1:0]  flit_cnt,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic                  err,
    output logic [VC_WIDTH-1:0]   err_vc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W:0]      FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [VC_WIDTH:0]   VC_LIMIT = (VC_WIDTH+1)'(N_VIRT_CHN);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    localparam logic [1:0] TYPE_HEAD = 2'b00;
    localparam logic [1:0] TYPE_BODY = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    typedef enum logic [0:0] {
        VC_IDLE   = 1'b0,
        VC_IN_PKT = 1'b1
    } vc_state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [FLIT_WIDTH-1:0] mem_data [DEPTH];
    logic [VC_WIDTH-1:0]   mem_vc   [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_next;
    logic [PTR_W:0]        count;
    logic [PTR_W:0]        count_next;
    logic                  push;
    logic                  pop;
    logic                  load_head;
    logic                  head_from_in;

    // Depends on stored count only, so out_ready never reaches in_ready.
    assign in_ready = (count != FULL_CNT);
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    assign rd_next = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;

    // The output registers are refreshed only when a new head appears:
    // after a pop that leaves data behind, or when an empty FIFO is filled.
    // Otherwise they hold, which keeps data stable and retains the last
    // flit while empty. If the new head slot is being written right now,
    // it must come from the input rather than the not-yet-written memory.
    assign load_head    = (count_next != '0) && (pop || (count == '0));
    assign head_from_in = push && (wr_ptr == rd_next);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_fdata;
            mem_vc[wr_ptr]   <= in_vc_id;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_fdata <= '0;
            out_vc_id <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            if (load_head) begin
                out_fdata <= head_from_in ? in_fdata : mem_data[rd_next];
                out_vc_id <= head_from_in ? in_vc_id : mem_vc[rd_next];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-VC framing checker
    // ------------------------------------------------------------------
    vc_state_t  vc_state      [N_VIRT_CHN];
    vc_state_t  vc_state_next [N_VIRT_CHN];
    logic [1:0] in_type;
    logic       vc_ok;
    logic       frame_err;

    assign in_type = in_fdata[FLIT_WIDTH-1 -: 2];
    assign vc_ok   = ({1'b0, in_vc_id} < VC_LIMIT);

    always_comb begin
        frame_err = 1'b0;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            vc_state_next[v] = vc_state[v];
        end
        if (push) begin
            if (!vc_ok || (in_type == 2'b11)) begin
                frame_err = 1'b1;
            end else begin
                for (int v = 0; v < N_VIRT_CHN; v++) begin
                    if (in_vc_id == VC_WIDTH'(v)) begin
                        case (vc_state[v])
                            VC_IDLE: begin
                                if (in_type == TYPE_HEAD) begin
                                    vc_state_next[v] = VC_IN_PKT;
                                end else begin
                                    frame_err = 1'b1;
                                end
                            end
                            VC_IN_PKT: begin
                                if (in_type == TYPE_TAIL) begin
                                    vc_state_next[v] = VC_IDLE;
                                end else if (in_type == TYPE_HEAD) begin
                                    frame_err = 1'b1;
                                end
                            end
                            default: vc_state_next[v] = VC_IDLE;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            for (int v = 0; v < N_VIRT_CHN; v++) begin
                vc_state[v] <= VC_IDLE;
            end
        end else begin
            for (int v = 0; v < N_VIRT_CHN; v++) begin
                vc_state[v] <= vc_state_next[v];
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics; clr_stats overrides any same-cycle update
    // ------------------------------------------------------------------
    logic pop_tail;
    assign pop_tail = pop && (out_fdata[FLIT_WIDTH-1 -: 2] == TYPE_TAIL);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            flit_cnt <= '0;
            pkt_cnt  <= '0;
            err      <= 1'b0;
            err_vc   <= '0;
        end else if (clr_stats) begin
            flit_cnt <= '0;
            pkt_cnt  <= '0;
            err      <= 1'b0;
            err_vc   <= '0;
        end else begin
            if (pop && (flit_cnt != CNT_MAX)) begin
                flit_cnt <= flit_cnt + 1'b1;
            end
            if (pop_tail && (pkt_cnt != CNT_MAX)) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
            // Only the first error since reset/clear records its VC.
            if (frame_err && !err) begin
                err    <= 1'b1;
                err_vc <= in_vc_id;
            end
        end
    end

endmodule
`default_nettype wire
